// File: rtl/sample_frame_sequencer.sv
// Frame sequencer: loads NCH input samples into DSP data memory, pulses the DSP program start,
// then reads NCH results back and streams them out under a valid/ready handshake.
`timescale 1ns / 1ps
module sample_frame_sequencer #(
  parameter int unsigned    DAW        = 10,
  parameter int unsigned    DWW        = 36,
  parameter int unsigned    NCH        = 8,
  parameter logic [DAW-1:0] IN_BASE    = DAW'(10'h000),
  parameter logic [DAW-1:0] OUT_BASE   = DAW'(10'h080),
  parameter int unsigned    RUN_CYCLES = 516
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  input  logic [23:0]    in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [23:0]    out_data,
  input  logic           out_ready,
  output logic           mem_we,
  output logic [DAW-1:0] mem_waddr,
  output logic [DWW-1:0] mem_wdata,
  output logic [DAW-1:0] mem_raddr,
  input  logic [DWW-1:0] mem_rdata,
  output logic           dsp_start,
  output logic           busy
);

  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned RCW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  typedef enum logic [2:0] {
    StLoad,
    StStart,
    StRun,
    StRdAddr,
    StRdCap,
    StPresent
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    i_q;
  logic [CW-1:0]    j_q;
  logic [RCW-1:0]   cnt_q;
  logic             mem_we_q;
  logic [DAW-1:0]   mem_waddr_q;
  logic [DWW-1:0]   mem_wdata_q;
  logic [DAW-1:0]   mem_raddr_q;
  logic             dsp_start_q;
  logic             out_valid_q;
  logic [23:0]      out_data_q;

  logic [DWW-1:0]   in_conv;
  logic [23:0]      out_conv;
  logic             rd_in_range;

  // Q0.23 -> Q5.30: sign-extend by five bits, pad seven fraction bits.
  // Q5.30 -> Q0.23: truncate when the integer bits are pure sign, otherwise saturate.
  always_comb begin
    in_conv     = {{(DWW-31){in_data[23]}}, in_data, 7'b0};
    rd_in_range = (mem_rdata[DWW-1:DWW-6] == {6{mem_rdata[DWW-1]}});
    if (rd_in_range) begin
      out_conv = mem_rdata[DWW-6:DWW-29];
    end else begin
      out_conv = mem_rdata[DWW-1] ? 24'h800000 : 24'h7FFFFF;
    end
  end

  logic unused_rdata_lsbs;
  assign unused_rdata_lsbs = ^mem_rdata[DWW-30:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StLoad;
      i_q         <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= IN_BASE;
      mem_wdata_q <= '0;
      mem_raddr_q <= OUT_BASE;
      dsp_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      dsp_start_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (in_valid) begin
            mem_we_q    <= 1'b1;
            mem_waddr_q <= IN_BASE + DAW'(i_q);
            mem_wdata_q <= in_conv;
            if (i_q == CW'(NCH - 1)) begin
              i_q         <= '0;
              dsp_start_q <= 1'b1;
              state_q     <= StStart;
            end else begin
              i_q <= i_q + CW'(1);
            end
          end
        end
        StStart: begin
          cnt_q   <= '0;
          state_q <= StRun;
        end
        StRun: begin
          if (cnt_q == RCW'(RUN_CYCLES - 1)) begin
            mem_raddr_q <= OUT_BASE + DAW'(j_q);
            state_q     <= StRdAddr;
          end else begin
            cnt_q <= cnt_q + RCW'(1);
          end
        end
        StRdAddr: begin
          state_q <= StRdCap;
        end
        StRdCap: begin
          out_data_q  <= out_conv;
          out_valid_q <= 1'b1;
          state_q     <= StPresent;
        end
        StPresent: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (j_q == CW'(NCH - 1)) begin
              j_q     <= '0;
              state_q <= StLoad;
            end else begin
              j_q         <= j_q + CW'(1);
              mem_raddr_q <= OUT_BASE + DAW'(j_q + CW'(1));
              state_q     <= StRdAddr;
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign busy      = (state_q != StLoad);
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_raddr = mem_raddr_q;
  assign dsp_start = dsp_start_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
